// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding and default link parameters.
package uart_defs;

   localparam int unsigned DEF_CLOCKS_PER_PULSE = 16;
   localparam int unsigned DEF_DATA_WIDTH       = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames, LSB first, mid-bit sampling, framing-error detect.
module uart_rx
   import uart_defs::*;
#(
   parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
   parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  rx_busy
);

   localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] HALF_CNT = CW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   uart_state_e           state;
   logic [CW-1:0]         c_clocks;
   logic [BW-1:0]         c_bits;
   logic [DATA_WIDTH-1:0] data;
   logic                  rx_s;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rx),
      .q    (rx_s)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         c_clocks   <= '0;
         c_bits     <= '0;
         data       <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  c_clocks <= '0;
                  c_bits   <= '0;
                  rx_busy  <= 1'b1;
               end
            end
            START: begin
               if (c_clocks == HALF_CNT) begin
                  c_clocks <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  c_clocks <= c_clocks + 1'b1;
               end
            end
            DATA: begin
               if (c_clocks == FULL_CNT) begin
                  c_clocks     <= '0;
                  data[c_bits] <= rx_s;
                  c_bits       <= c_bits + 1'b1;
                  if (c_bits == LAST_BIT) state <= STOP;
               end else begin
                  c_clocks <= c_clocks + 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
               if (c_clocks == FULL_CNT) begin
                  c_clocks <= '0;
                  if (rx_s) begin
                     data_out   <= data;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                     rx_busy    <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  c_clocks <= c_clocks + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
